// File: rtl/led_pkg.sv
// Shared display-mode encodings, flash FSM states and counter-width helper.
package led_pkg;

  typedef enum logic [1:0] {
    MODE_AUTO  = 2'd0,
    MODE_LEVEL = 2'd1,
    MODE_CYLON = 2'd2,
    MODE_LAMP  = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    FL_IDLE = 2'd0,
    FL_ON   = 2'd1,
    FL_OFF  = 2'd2
  } flash_state_e;

  // Bits needed to count 0..n-1, never less than one.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/led_event_display_if.sv
// Status/event inputs and LED outputs of the front-panel display block.
interface led_event_display_if #(
  parameter int unsigned N_EVT = 4,
  parameter int unsigned N_BAR = 8
);
  import led_pkg::*;

  mode_e                  mode_i;
  logic [N_EVT-1:0]       events_i;
  logic [N_BAR-1:0]       level_i;
  logic                   activity_i;
  logic                   resync_i;
  logic                   locked_i;
  logic                   link_ok_i;
  logic [N_BAR+N_EVT:0]   led_o;
  logic                   cylon_active_o;

  modport master (
    output mode_i, events_i, level_i, activity_i, resync_i, locked_i, link_ok_i,
    input  led_o, cylon_active_o
  );

  modport slave (
    input  mode_i, events_i, level_i, activity_i, resync_i, locked_i, link_ok_i,
    output led_o, cylon_active_o
  );

endinterface

// File: rtl/led_flash_stretcher.sv
// Stretches a one-cycle event strobe into a fixed lit window followed by a
// fixed dark window; events arriving while busy coalesce into one re-flash.
module led_flash_stretcher
  import led_pkg::*;
#(
  parameter int unsigned ON_CYCLES  = 4000000,
  parameter int unsigned OFF_CYCLES = 4000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic event_i,
  output logic lit_o
);

  localparam int unsigned CW = cnt_width((ON_CYCLES > OFF_CYCLES) ? ON_CYCLES : OFF_CYCLES);
  localparam logic [CW-1:0] ON_LAST  = CW'(ON_CYCLES - 1);
  localparam logic [CW-1:0] OFF_LAST = CW'(OFF_CYCLES - 1);

  flash_state_e   state;
  logic [CW-1:0]  cnt;
  logic           pending;

  // IDLE/ON/OFF sequencer; lit_o is registered alongside the state (high exactly while in ON).
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= FL_IDLE;
      cnt     <= '0;
      pending <= 1'b0;
      lit_o   <= 1'b0;
    end else begin
      case (state)
        FL_IDLE: begin
          if (event_i) begin
            state <= FL_ON;
            cnt   <= '0;
            lit_o <= 1'b1;
          end
        end
        FL_ON: begin
          pending <= pending | event_i;
          if (cnt == ON_LAST) begin
            state <= FL_OFF;
            cnt   <= '0;
            lit_o <= 1'b0;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        FL_OFF: begin
          if (cnt == OFF_LAST) begin
            // an event in the final dark cycle counts as pending: no IDLE gap
            if (pending || event_i) begin
              state <= FL_ON;
              lit_o <= 1'b1;
            end else begin
              state <= FL_IDLE;
            end
            cnt     <= '0;
            pending <= 1'b0;
          end else begin
            cnt     <= cnt + CW'(1);
            pending <= pending | event_i;
          end
        end
        default: begin
          state   <= FL_IDLE;
          cnt     <= '0;
          pending <= 1'b0;
          lit_o   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/led_event_display.sv
// Front-panel LED driver: rate bar / cylon sweep, per-event flashes and a
// lock-dependent heartbeat, with forced display modes and lamp test.
module led_event_display
  import led_pkg::*;
#(
  parameter int unsigned N_EVT       = 4,
  parameter int unsigned N_BAR       = 8,
  parameter int unsigned FLASH_ON    = 4000000,
  parameter int unsigned FLASH_OFF   = 4000000,
  parameter int unsigned STEP_CYCLES = 2000000,
  parameter int unsigned BLINK_BITS  = 21
) (
  input  logic              clk,
  input  logic              rst_n,
  led_event_display_if.slave bus
);

  localparam int unsigned SW = cnt_width(STEP_CYCLES);
  localparam int unsigned PW = cnt_width(N_BAR);
  localparam logic [SW-1:0] STEP_LAST  = SW'(STEP_CYCLES - 1);
  localparam logic [PW-1:0] POS_TOP    = PW'(N_BAR - 1);
  localparam logic [PW-1:0] POS_TOP_M1 = PW'(N_BAR - 2);

  logic [N_EVT-1:0]      flash;
  logic [BLINK_BITS-1:0] hb_cnt;
  logic [SW-1:0]         step_cnt;
  logic [PW-1:0]         pos;
  logic                  dir_up;
  logic                  cyl_next;
  logic                  heartbeat;
  logic [N_BAR-1:0]      cylon_bar;
  logic [N_BAR-1:0]      alt_bar;
  logic [N_BAR-1:0]      bar;

  for (genvar g = 0; g < N_EVT; g++) begin : g_flash
    led_flash_stretcher #(
      .ON_CYCLES  (FLASH_ON),
      .OFF_CYCLES (FLASH_OFF)
    ) u_flash (
      .clk     (clk),
      .rst_n   (rst_n),
      .event_i (bus.events_i[g]),
      .lit_o   (flash[g])
    );
  end

  // Free-running heartbeat counter.
  always_ff @(posedge clk) begin
    if (!rst_n) hb_cnt <= '0;
    else        hb_cnt <= hb_cnt + BLINK_BITS'(1);
  end

  // Cylon position: steps every STEP_CYCLES and bounces off both ends without repeating them.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      step_cnt <= '0;
      pos      <= '0;
      dir_up   <= 1'b1;
    end else if (step_cnt == STEP_LAST) begin
      step_cnt <= '0;
      if (dir_up) begin
        if (pos == POS_TOP) begin
          pos    <= POS_TOP_M1;
          dir_up <= 1'b0;
        end else begin
          pos <= pos + PW'(1);
        end
      end else begin
        if (pos == '0) begin
          pos    <= PW'(1);
          dir_up <= 1'b1;
        end else begin
          pos <= pos - PW'(1);
        end
      end
    end else begin
      step_cnt <= step_cnt + SW'(1);
    end
  end

  // Next display fields; cylon arming uses its next value so the bar and the flag switch together.
  always_comb begin
    cyl_next = bus.cylon_active_o;
    if (bus.activity_i) cyl_next = 1'b0;
    if (bus.resync_i)   cyl_next = 1'b1;

    cylon_bar      = '0;
    cylon_bar[pos] = 1'b1;

    alt_bar = '0;
    for (int unsigned i = 0; i < N_BAR; i++) begin
      alt_bar[i] = ~i[0] ^ hb_cnt[BLINK_BITS-1];
    end

    heartbeat = (bus.locked_i ? hb_cnt[BLINK_BITS-1] : hb_cnt[BLINK_BITS-3]) & bus.link_ok_i;

    bar = bus.level_i;
    case (bus.mode_i)
      MODE_AUTO: begin
        if (!bus.locked_i) bar = alt_bar;
        else if (cyl_next) bar = cylon_bar;
        else               bar = bus.level_i;
      end
      MODE_LEVEL: bar = bus.level_i;
      MODE_CYLON: bar = cylon_bar;
      default:    bar = bus.level_i;
    endcase
  end

  // Registered outputs; lamp test overrides the whole LED word without touching internal state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bus.led_o          <= '0;
      bus.cylon_active_o <= 1'b1;
    end else begin
      bus.cylon_active_o <= cyl_next;
      if (bus.mode_i == MODE_LAMP) bus.led_o <= '1;
      else                         bus.led_o <= {heartbeat, flash, bar};
    end
  end

endmodule

// File: doc/led_event_display.md
LED_EVENT_DISPLAY -- requirements
Module: led_event_display

Interface
REQ-001 Parameter N_EVT, default 4: number of event-flash channels.
REQ-002 Parameter N_BAR, default 8: width of rate bar / cylon field, minimum 2.
REQ-003 Parameter FLASH_ON, default 4000000: cycles a flash LED stays lit.
REQ-004 Parameter FLASH_OFF, default 4000000: forced dark cycles after each flash.
REQ-005 Parameter STEP_CYCLES, default 2000000: cycles per cylon position step.
REQ-006 Parameter BLINK_BITS, default 21: heartbeat counter width, minimum 4.
REQ-007 One clock; reset is synchronous and active-low.
REQ-008 clock  in  1  system clock, 40 MHz LHC.
REQ-009 reset  in  1  synchronous active-low reset.
REQ-010 mode_i  in  2  0 auto, 1 force level, 2 force cylon, 3 lamp test.
REQ-011 events_i  in  N_EVT  single-cycle event strobes (L1A, BC0, resync, ...).
REQ-012 level_i  in  N_BAR  thermometer rate bar, passed through in level display.
REQ-013 activity_i  in  1  high when the data path has seen activity this cycle.
REQ-014 resync_i  in  1  resync strobe; re-arms cylon display.
REQ-015 locked_i  in  1  clock-manager locked.
REQ-016 link_ok_i  in  1  link ready.
REQ-017 led_o  out  N_BAR+N_EVT+1  [N_BAR-1:0] bar, [N_BAR+N_EVT-1:N_BAR] flashes, MSB heartbeat.
REQ-018 cylon_active_o  out  1  cylon display armed.

Function
REQ-019 led_o and cylon_active_o SHALL be registered; one cycle from inputs/internal state to outputs.
REQ-020 Each flash channel SHALL run FSM IDLE/ON/OFF: IDLE->ON on event; ON lit exactly FLASH_ON cycles ->OFF; OFF dark exactly FLASH_OFF cycles ->IDLE.
REQ-021 Event during ON or OFF SHALL set a one-bit pending flag (further events coalesce); at OFF end, pending SHALL give OFF->ON and clear pending.
REQ-022 Event in the last OFF cycle SHALL be treated as pending (OFF->ON directly, no IDLE cycle).
REQ-023 Heartbeat counter SHALL free-run BLINK_BITS wide, wrapping to 0; heartbeat = counter MSB when locked_i, counter bit BLINK_BITS-3 (4x rate) when not locked, ANDed with link_ok_i.
REQ-024 Cylon SHALL be one-hot position 0..N_BAR-1 with direction, advancing every STEP_CYCLES; at N_BAR-1 next is N_BAR-2, at 0 next is 1 (bounce, no end repeat).
REQ-025 cylon_active SHALL clear on activity_i and set on resync_i; simultaneous: resync_i wins.
REQ-026 Mode 0 bar field: !locked_i -> alternating 0101... pattern inverted on each heartbeat MSB toggle; else cylon_active ? cylon : level_i.
REQ-027 Mode 1 bar = level_i; mode 2 bar = cylon; flash and heartbeat fields unaffected in modes 0-2.
REQ-028 Mode 3 SHALL drive all led_o bits 1 while held; internal FSMs/counters continue undisturbed.
REQ-029 Mode change SHALL take effect on the next led_o update without resetting any state.

Reset
REQ-030 While reset low: led_o=0, cylon_active_o=1 (visible next cycle), all flash FSMs IDLE, pending 0, all counters 0, cylon position 0 direction up.
REQ-031 Reset mid-flash SHALL abort ON/OFF immediately; first event after reset release starts a full FLASH_ON.

Structure
REQ-032 Mode encodings (AUTO, LEVEL, CYLON, LAMP) SHALL live in shared package led_pkg.
REQ-033 Flash FSM SHALL be sub-module led_flash_stretcher (params ON/OFF cycles), instantiated N_EVT times.
REQ-034 Counter widths SHALL be derived by clog2 of parameters; no fixed widths.

Verification (N_EVT=2, N_BAR=4, FLASH_ON=4, FLASH_OFF=3, STEP_CYCLES=2, BLINK_BITS=4)
REQ-035 Single event on ch0 at cycle 10 -> led_o[4] high cycles 12-15, low from 16; ch1 stays 0.
REQ-036 Events on ch0 at cycles 10, 12, 17 -> one lit window 12-15, dark 16-18, second window 19-22, then IDLE.
REQ-037 Mode 0, locked, no activity -> bar 0001,0010,0100,1000,0100,0010 each held 2 cycles; activity_i pulse -> bar = level_i next update.
REQ-038 activity_i and resync_i same cycle -> cylon_active_o stays 1; locked_i low -> bar alternates 0101/1010, heartbeat period 4 cycles.
REQ-039 Mode 3 during a flash -> led_o = all 1; return to mode 0 -> flash resumes on original schedule.
REQ-040 reset low at cycle 13 during flash -> led_o=0 next cycle, cylon_active_o=1; event after release -> full 4-cycle flash.
